// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and constant fields used by the configuration master.
package axi_pkg;

    // Response codes carried on BRESP/RRESP and forwarded to the requester.
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Burst type encodings.
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    // Modifiable, bufferable; unprivileged, secure, data access.
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;

    // Bytes-per-beat encoding for a full-width single beat.
    function automatic logic [2:0] axi_size(input int strb_width);
        return 3'($clog2(strb_width));
    endfunction

    // A response whose ID or framing is wrong cannot be trusted, so it is
    // reported as a slave error regardless of what the slave claimed.
    function automatic logic [1:0] resolve_resp(input logic      id_match,
                                                input logic      framing_ok,
                                                input logic [1:0] resp);
        return (id_match && framing_ok) ? resp : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_config_master.sv
// Single-beat AXI4 master: converts one register read/write request at a
// time into an AXI4 transaction and returns exactly one response for it.
module axi_config_master
    import axi_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter int          ID_WIDTH   = 8,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    // Request port
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    // Response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    // Write address channel
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic [3:0]            m_axi_awregion,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // Write data channel
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // Write response channel
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    // Read address channel
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [3:0]            m_axi_arregion,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // Read data channel
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } state_e;

    localparam logic [ID_WIDTH-1:0] ID_L     = ID_WIDTH'(AXI_ID);
    localparam logic [2:0]          SIZE_L   = axi_size(STRB_WIDTH);

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    aw_valid_q;
    logic                    w_valid_q;
    logic                    b_ready_q;
    logic                    ar_valid_q;
    logic                    r_ready_q;
    logic                    rsp_valid_q;
    logic                    rsp_write_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    logic [1:0]              b_resp_d;
    logic [1:0]              r_resp_d;
    logic                    aw_done_d;
    logic                    w_done_d;

    // Response checking and write-channel completion tracking.
    always_comb begin
        b_resp_d  = resolve_resp(m_axi_bid == ID_L, 1'b1, m_axi_bresp);
        r_resp_d  = resolve_resp(m_axi_rid == ID_L, m_axi_rlast, m_axi_rresp);
        // A channel is done if it already handshook or handshakes this cycle,
        // so AW and W may complete in either order or together.
        aw_done_d = !aw_valid_q || m_axi_awready;
        w_done_d  = !w_valid_q  || m_axi_wready;
    end

    // Request payload capture on acceptance.
    // NOTE: the payload registers carry no reset; they are only observed while
    // a valid they belong to is high, and every valid is reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // Transaction FSM with registered channel valids/readies and response.
    // NOTE: non-blocking assignments throughout, so every output reflects the
    // state entered at this edge and no AXI input reaches an AXI output
    // combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (req_write) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= WRITE;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    if (m_axi_awready) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        w_valid_q <= 1'b0;
                    end
                    if (aw_done_d && w_done_d) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        b_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= b_resp_d;
                        state_q     <= RESP;
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RDATA;
                    end
                end
                RDATA: begin
                    // The beat is consumed even when rlast is wrong; the
                    // error is reported through the response code instead.
                    if (m_axi_rvalid) begin
                        r_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= m_axi_rdata;
                        rsp_resp_q  <= r_resp_d;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;

    assign m_axi_awid     = ID_L;
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = SIZE_L;
    assign m_axi_awburst  = BURST_INCR;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = CACHE_DEFAULT;
    assign m_axi_awprot   = PROT_DEFAULT;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awvalid  = aw_valid_q;

    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = wstrb_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_wvalid   = w_valid_q;

    assign m_axi_bready   = b_ready_q;

    assign m_axi_arid     = ID_L;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = SIZE_L;
    assign m_axi_arburst  = BURST_INCR;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = CACHE_DEFAULT;
    assign m_axi_arprot   = PROT_DEFAULT;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arvalid  = ar_valid_q;

    assign m_axi_rready   = r_ready_q;

endmodule

// File: tb/tb_axi_config_master.sv
// Directed bench for axi_config_master with a behavioural AXI4 slave and a
// response scoreboard.
module tb_axi_config_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 8;

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic          m_axi_awlock, m_axi_arlock;
    logic [3:0]    m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic [3:0]    m_axi_awregion, m_axi_arregion;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic          m_axi_wlast, m_axi_bvalid, m_axi_bready;
    logic          m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;

    axi_config_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .AXI_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- slave configuration and observations ----------------
    int          cfg_aw_delay = 0;
    int          cfg_r_delay  = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [IW-1:0] cfg_bid    = '0;
    logic [IW-1:0] cfg_rid    = '0;
    logic [1:0]  cfg_rresp    = 2'b00;
    logic        cfg_rlast    = 1'b1;
    logic [DW-1:0] cfg_rdata  = '0;

    int          aw_vcycles = 0, w_vcycles = 0, b_hs_cnt = 0, r_hs_cnt = 0;
    bit          aw_unstable = 0;
    logic [AW-1:0] aw_addr_first, slv_awaddr, slv_araddr;
    logic [DW-1:0] slv_wdata;
    logic [SW-1:0] slv_wstrb;
    logic        slv_wlast;
    logic [7:0]  slv_awlen, slv_arlen;
    logic [2:0]  slv_awsize, slv_arsize;
    logic [1:0]  slv_awburst, slv_arburst;

    // Behavioural slave: works on the falling edge, where the previous
    // rising-edge handshakes are inferred from the values it left behind.
    initial begin : axi_slave
        bit p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
        bit aw_got, w_got, ar_got;
        int aw_cnt, r_cnt;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_rid = '0;
        m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        {aw_got, w_got, ar_got} = '0;
        aw_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
                {aw_got, w_got, ar_got} = '0;
                aw_cnt = 0; r_cnt = 0;
            end else begin
                if (m_axi_awvalid) begin
                    if (aw_vcycles == 0) aw_addr_first = m_axi_awaddr;
                    else if (m_axi_awaddr !== aw_addr_first) aw_unstable = 1;
                    aw_vcycles++;
                end
                if (m_axi_wvalid) w_vcycles++;

                if (p_awv && p_awr) begin aw_got = 1; m_axi_awready = 0; end
                if (p_wv && p_wr) begin w_got = 1; m_axi_wready = 0; end
                if (p_bv && p_br) begin
                    m_axi_bvalid = 0; b_hs_cnt++; aw_got = 0; w_got = 0; aw_cnt = 0;
                end
                if (p_arv && p_arr) begin ar_got = 1; m_axi_arready = 0; end
                if (p_rv && p_rr) begin m_axi_rvalid = 0; r_hs_cnt++; ar_got = 0; r_cnt = 0; end

                if (m_axi_awvalid && !aw_got && !m_axi_awready) begin
                    if (aw_cnt >= cfg_aw_delay) begin
                        m_axi_awready = 1;
                        slv_awaddr = m_axi_awaddr; slv_awlen = m_axi_awlen;
                        slv_awsize = m_axi_awsize; slv_awburst = m_axi_awburst;
                    end else begin
                        aw_cnt++;
                    end
                end
                if (m_axi_wvalid && !w_got && !m_axi_wready) begin
                    m_axi_wready = 1;
                    slv_wdata = m_axi_wdata; slv_wstrb = m_axi_wstrb; slv_wlast = m_axi_wlast;
                end
                if (aw_got && w_got && !m_axi_bvalid) begin
                    m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; m_axi_bid = cfg_bid;
                end
                if (m_axi_arvalid && !ar_got && !m_axi_arready) begin
                    m_axi_arready = 1;
                    slv_araddr = m_axi_araddr; slv_arlen = m_axi_arlen;
                    slv_arsize = m_axi_arsize; slv_arburst = m_axi_arburst;
                end
                if (ar_got && !m_axi_rvalid) begin
                    if (r_cnt >= cfg_r_delay) begin
                        m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
                        m_axi_rid = cfg_rid; m_axi_rlast = cfg_rlast;
                    end else begin
                        r_cnt++;
                    end
                end

                p_awv = m_axi_awvalid; p_awr = m_axi_awready;
                p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;
                p_bv  = m_axi_bvalid;  p_br  = m_axi_bready;
                p_arv = m_axi_arvalid; p_arr = m_axi_arready;
                p_rv  = m_axi_rvalid;  p_rr  = m_axi_rready;
            end
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [DW-1:0] exp_rdata,
                            input logic [1:0] exp_resp);
        int budget = 50;
        exp_q.push_back('{write: wr, rdata: exp_rdata, resp: exp_resp});
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("req_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_arrive", rsp_valid, 1);
    endtask

    task automatic pop_exp(input string tag, output exp_t e);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: response with empty scoreboard", tag);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic cmp_rsp(input string tag, input exp_t e);
        check({tag, "_write"}, rsp_write, e.write);
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_resp"},  rsp_resp,  e.resp);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("idle_req_ready", req_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
    endtask

    task automatic do_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [SW-1:0] strb,
                          input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp,
                          input int exp_lat);
        int   lat;
        exp_t e;
        send_req(wr, addr, data, strb, exp_rdata, exp_resp);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, exp_lat);
        pop_exp(tag, e);
        cmp_rsp(tag, e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        exp_t e;
        int   base;
        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_write", rsp_write, 0);
        #2 rst = 0;
        @(negedge clk);

        // Basic write, zero-wait slave
        do_txn("wr_basic", 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 3);
        check("wr_awaddr", slv_awaddr, 32'h10);
        check("wr_wdata", slv_wdata, 32'hDEADBEEF);
        check("wr_wstrb", slv_wstrb, 4'hF);
        check("wr_wlast", slv_wlast, 1);
        check("wr_awlen", slv_awlen, 0);
        check("wr_awsize", slv_awsize, 2);
        check("wr_awburst", slv_awburst, 2'b01);
        check("wr_awcache", m_axi_awcache, 4'b0011);
        check("wr_awid", m_axi_awid, 0);
        ack_rsp();

        // Basic read
        cfg_rdata = 32'h12345678;
        do_txn("rd_basic", 0, 32'h20, 32'h0, 4'h0, 32'h12345678, 2'b00, 3);
        check("rd_araddr", slv_araddr, 32'h20);
        check("rd_arlen", slv_arlen, 0);
        check("rd_arsize", slv_arsize, 2);
        check("rd_arburst", slv_arburst, 2'b01);
        ack_rsp();

        // Delayed awready, immediate wready, unaligned address
        aw_vcycles = 0; w_vcycles = 0; aw_unstable = 0; base = b_hs_cnt;
        cfg_aw_delay = 4;
        do_txn("wr_awdly", 1, 32'h43, 32'hA5A50001, 4'b0011, 32'h0, 2'b00, 7);
        check("awdly_aw_cycles", aw_vcycles, 5);
        check("awdly_w_cycles", w_vcycles, 1);
        check("awdly_addr_stable", aw_unstable, 0);
        check("awdly_awaddr", slv_awaddr, 32'h43);
        check("awdly_wstrb", slv_wstrb, 4'b0011);
        ack_rsp();
        repeat (3) @(negedge clk);
        check("awdly_single_rsp", rsp_valid, 0);
        check("awdly_b_count", b_hs_cnt - base, 1);
        cfg_aw_delay = 0;

        // DECERR passthrough on write
        cfg_bresp = 2'b11;
        do_txn("wr_decerr", 1, 32'h30, 32'h1, 4'h1, 32'h0, 2'b11, 3);
        ack_rsp();
        cfg_bresp = 2'b00;

        // BID mismatch forces SLVERR
        cfg_bid = 8'h05;
        do_txn("wr_bid", 1, 32'h34, 32'h2, 4'h2, 32'h0, 2'b10, 3);
        ack_rsp();
        cfg_bid = '0;

        // RID mismatch forces SLVERR
        cfg_rid = 8'h01; cfg_rdata = 32'hCAFE0000;
        do_txn("rd_rid", 0, 32'h24, 32'h0, 4'h0, 32'hCAFE0000, 2'b10, 3);
        ack_rsp();
        cfg_rid = '0;

        // Missing rlast forces SLVERR, beat still consumed
        base = r_hs_cnt;
        cfg_rlast = 0; cfg_rdata = 32'h0000BEEF;
        do_txn("rd_nolast", 0, 32'h28, 32'h0, 4'h0, 32'h0000BEEF, 2'b10, 3);
        check("nolast_consumed", r_hs_cnt - base, 1);
        ack_rsp();
        cfg_rlast = 1;

        // Response backpressure with a pending request
        cfg_rdata = 32'h0BADF00D; cfg_rresp = 2'b01;
        send_req(0, 32'h50, 32'h0, 4'h0, 32'h0BADF00D, 2'b01);
        begin
            int lat;
            wait_rsp(lat);
        end
        pop_exp("bp", e);
        req_valid = 1; req_write = 1; req_addr = 32'h60; req_wdata = 32'h11112222; req_wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp_rsp("bp_hold", e);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_awvalid", m_axi_awvalid, 0);
            check("bp_arvalid", m_axi_arvalid, 0);
        end
        cfg_rresp = 2'b00;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        do_txn("bp_next", 1, 32'h60, 32'h11112222, 4'hF, 32'h0, 2'b00, 3);
        check("bp_next_wdata", slv_wdata, 32'h11112222);
        ack_rsp();

        // Asynchronous reset while waiting for read data
        cfg_r_delay = 20;
        send_req(0, 32'h70, 32'h0, 4'h0, 32'h0, 2'b00);
        for (int i = 0; i < 10 && !m_axi_rready; i++) @(negedge clk);
        check("rdata_state_rready", m_axi_rready, 1);
        #2 rst = 1;
        #1;
        check("arst_rready", m_axi_rready, 0);
        check("arst_arvalid", m_axi_arvalid, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("arst_next_rready", m_axi_rready, 0);
        check("arst_next_rsp_valid", rsp_valid, 0);
        check("arst_rsp_rdata", rsp_rdata, 0);
        check("arst_rsp_resp", rsp_resp, 0);
        check("arst_rsp_write", rsp_write, 0);
        exp_q.delete();
        cfg_r_delay = 0;
        #2 rst = 0;
        repeat (2) @(negedge clk);
        check("arst_no_rsp", rsp_valid, 0);
        cfg_rdata = 32'h76543210;
        do_txn("rd_after_rst", 0, 32'h74, 32'h0, 4'h0, 32'h76543210, 2'b00, 3);
        check("after_rst_araddr", slv_araddr, 32'h74);
        ack_rsp();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_config_master.md
# axi_config_master

AXI4 single-beat master that turns simple register read/write requests into AXI4 transactions. It is the initiator counterpart of `axi_config`: a controller or test sequencer drives the request port, and `m_axi_*` connects to any AXI4 slave, including `axi_config`. Only one transaction is outstanding at a time. Every request produces exactly one response carrying read data and the AXI response code.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (8..1024, power of two)
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- ID_WIDTH, 8, AXI ID width
- AXI_ID, 0, constant ID driven on awid/arid

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  STRB_WIDTH  write byte enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  AXI response code
- m_axi_aw*  out  AXI4 write address channel: id, addr, len, size, burst, lock, cache, prot, qos, region, valid; awready in
- m_axi_w*  out  AXI4 write data channel: data, strb, last, valid; wready in
- m_axi_b*  in  AXI4 write response channel: id, resp, valid; bready out
- m_axi_ar*  out  AXI4 read address channel: same signal set as AW; arready in
- m_axi_r*  in  AXI4 read data channel: id, data, resp, last, valid; rready out

## Operation
- FSM states: IDLE, WRITE (AW/W pending), WRESP, RADDR, RDATA, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, wstrb and write. Next state is WRITE for writes, RADDR for reads.
- WRITE: awvalid and wvalid are both raised. Each drops independently on its own handshake. Move to WRESP when both have completed, in any order or in the same cycle.
- WRESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0, and go to RESP.
- RADDR: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and rresp, then go to RESP.
- RESP: rsp_valid=1. Go to IDLE on rsp_ready.
- ID mismatch: if bid or rid ≠ AXI_ID, rsp_resp is forced to SLVERR (2'b10).
- Read with rlast=0: rsp_resp is forced to SLVERR, and the beat is still consumed.
- Constant fields:
  - len=0, size=$clog2(STRB_WIDTH), burst=INCR (2'b01)
  - lock=0, cache=4'b0011, prot=3'b000, qos=0, region=0, wlast=1
- Addresses are passed through unaligned, with no alignment check.
- Reset, asynchronous and at any point mid-transaction:
  - state returns to IDLE
  - all valids and readies drop to 0, req_ready=1, rsp_valid=0
  - rsp_rdata=0, rsp_resp=0, rsp_write=0
  - the in-flight transaction is abandoned and no response is generated

## Timing
- Address, data and valid outputs are registered; no combinational path exists from any AXI input to any AXI output.
- req accepted in cycle N → awvalid/wvalid (or arvalid) high in cycle N+1.
- bvalid&bready or rvalid&rready in cycle M → rsp_valid high in cycle M+1.
- Minimum write latency with a zero-wait slave: request to rsp_valid = 3 cycles. Reads are the same.
- Back-to-back throughput: one transaction per 4 cycles minimum, because RESP→IDLE costs one cycle.
- An AXI valid, once raised, is held with stable payload until its handshake completes.
- req_ready is 0 in every state except IDLE. rsp_* is stable while rsp_valid=1 and rsp_ready=0.
- The block never asserts bready or rready outside WRESP or RDATA.

## Structure
- Shared package axi_pkg holds:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR (2'b00..2'b11)
  - burst codes FIXED/INCR/WRAP
  - default cache/prot constants
- The FSM state typedef is local to the module.
- No sub-module; a single FSM module of roughly 200 lines.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, against axi_config with zero wait → wr pulse at waddr 0x10, wdata 0xDEADBEEF; rsp_write=1, rsp_resp=OKAY.
- Read addr 0x20 with slave rdata 0x12345678 → arlen=0, arsize=2; rsp_rdata=0x12345678, rsp_resp=OKAY 3 cycles after the request.
- awready delayed 5 cycles, wready immediate → wvalid drops after 1 cycle, awvalid holds 5 cycles with stable addr; exactly one response.
- Slave returns bresp=DECERR; in a second run, rid=AXI_ID+1 → rsp_resp=DECERR and SLVERR respectively.
- rsp_ready held low 10 cycles with req_valid high → req_ready stays 0 and no new AW/AR is issued; rsp fields stay stable.
- rst asserted while in RDATA → next cycle rready=0, arvalid=0, req_ready=1, rsp_valid=0; a following read completes normally.
